// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch front end.
// Owns the PC and drives the instruction-memory address and stall pins. Each returned
// word is captured with its PC into a small FIFO that decode drains through a
// valid/ready handshake. A redirect from execute flushes the FIFO and the in-flight
// word, and fetch restarts at the target.
//
// Ports
//   clk            clock, all state updates on posedge
//   rst_n          synchronous reset, active-low
//   imem_addr      byte address presented to instruction memory
//   imem_stall     1 = memory keeps its latched address (no fetch this cycle)
//   imem_data      word for the address issued in the previous cycle
//   redirect_valid execute requests a PC change this cycle
//   redirect_pc    redirect target, bits [1:0] ignored
//   if_valid       FIFO head holds an instruction for decode
//   if_ready       decode accepts the head this cycle
//   if_pc          PC of the head entry
//   if_instr       instruction word of the head entry
module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_stall,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned OW = CW + 1;

    logic [31:0]   r_pc;
    logic          r_inflight_v;
    logic [31:0]   r_inflight_pc;
    logic [31:0]   r_buf_pc    [BUF_DEPTH];
    logic [31:0]   r_buf_instr [BUF_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [31:0]   w_redirect_addr;
    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic [OW-1:0] w_occ;
    logic          w_unused_rpc_lsb;

    // Low address bits of the redirect target are dropped by design.
    assign w_unused_rpc_lsb = ^redirect_pc[1:0];
    assign w_redirect_addr  = {redirect_pc[31:2], 2'b00};

    // Head is hidden during reset and during a redirect so the flushed entry is never taken.
    assign if_valid = rst_n & (r_count != '0) & ~redirect_valid;
    assign if_pc    = r_buf_pc[r_rd_ptr];
    assign if_instr = r_buf_instr[r_rd_ptr];
    assign w_pop    = if_valid & if_ready;

    // Words already owed to the FIFO (stored + in flight) after this cycle's pop;
    // issuing only when that leaves room guarantees a push never finds the FIFO full.
    assign w_occ   = OW'(r_count) + OW'(r_inflight_v) - OW'(w_pop);
    assign w_issue = rst_n & (redirect_valid | (w_occ < OW'(BUF_DEPTH)));

    assign imem_stall = ~w_issue;
    assign imem_addr  = ~rst_n ? RESET_PC : (redirect_valid ? w_redirect_addr : r_pc);

    // A redirect discards the word returning for the previous (wrong-path) fetch.
    assign w_push = r_inflight_v & ~redirect_valid;

    // PC, in-flight tracking and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_inflight_v  <= 1'b0;
            r_inflight_pc <= RESET_PC;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
        end else begin
            if (w_issue) begin
                r_pc          <= imem_addr + 32'd4;
                r_inflight_v  <= 1'b1;
                r_inflight_pc <= imem_addr;
            end else begin
                r_inflight_v  <= 1'b0;
            end

            if (redirect_valid) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // FIFO storage; contents are only meaningful below r_count so no reset is needed.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_buf_pc[r_wr_ptr]    <= r_inflight_pc;
            r_buf_instr[r_wr_ptr] <= imem_data;
        end
    end

endmodule
